// File: rtl/poly_conv_sequencer.sv
// Coefficient-serial cyclic convolution c = a*b mod (x^N - 1) mod 2^WIDTH.
// Optional Sq reduction (subtract c[N-1]) when SQ_REDUCE_EN is defined.
module poly_conv_sequencer #(
  parameter int N     = 701,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMP,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_k;

  logic [WIDTH-1:0] r_a   [N];
  logic [WIDTH-1:0] r_b   [N];
  logic [WIDTH-1:0] r_acc [N];

  logic             w_i_last;
  logic             w_j_last;
  logic             w_k_last;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_mac;
  logic [WIDTH-1:0] w_acc_k;
  logic [WIDTH-1:0] w_res;

  assign w_i_last = (r_i == LAST);
  assign w_j_last = (r_j == LAST);
  assign w_k_last = (r_k == LAST);

  // Only the low WIDTH bits of the product matter mod 2^WIDTH.
  assign w_prod  = r_a[r_i] * r_b[r_j];
  assign w_mac   = r_acc[r_k] + w_prod;
  assign w_acc_k = r_acc[r_k];

`ifdef SQ_REDUCE_EN
  assign w_res = w_acc_k - r_acc[LAST];
`else
  assign w_res = w_acc_k;
`endif

  assign out_data = (r_state == S_OUT) ? w_res : '0;
  assign out_last = (r_state == S_OUT) && w_k_last;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_k_last) w_next = S_COMP;
      end
      S_COMP: begin
        busy = 1'b1;
        if (w_i_last && w_j_last) w_next = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && w_k_last) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // Index counters: k is load/output index and the wrapping (i+j) mod N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          r_i <= '0;
          r_j <= '0;
          if (in_valid) r_k <= w_k_last ? '0 : r_k + 1'b1;
        end
        S_COMP: begin
          if (w_j_last) begin
            r_j <= '0;
            r_i <= w_i_last ? '0 : r_i + 1'b1;
            r_k <= w_i_last ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
            r_k <= w_k_last ? '0 : r_k + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) r_k <= w_k_last ? '0 : r_k + 1'b1;
        end
        default: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
      endcase
    end
  end

  // Operand and accumulator storage; acc is cleared as each beat loads.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && in_valid) begin
      r_a[r_k]   <= in_a;
      r_b[r_k]   <= in_b;
      r_acc[r_k] <= '0;
    end else if (r_state == S_COMP) begin
      r_acc[r_k] <= w_mac;
    end
  end

endmodule

// File: tb/tb_poly_conv_sequencer.sv
// Bench for poly_conv_sequencer (N=4, WIDTH=13).
// Reference: direct double sum over i,j into (i+j) mod N.
module tb_poly_conv_sequencer;

  localparam int N    = 4;
  localparam int W    = 13;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  int ta [N];
  int tb_ [N];
  int te [N];

  always #5 clk = ~clk;

  poly_conv_sequencer #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set4(input int a0, a1, a2, a3, b0, b1, b2, b3);
    ta[0] = a0; ta[1] = a1; ta[2] = a2; ta[3] = a3;
    tb_[0] = b0; tb_[1] = b1; tb_[2] = b2; tb_[3] = b3;
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++) begin
      ta[i]  = int'($urandom_range(0, MASK));
      tb_[i] = int'($urandom_range(0, MASK));
    end
  endtask

  task automatic model();
    int last;
    for (int k = 0; k < N; k++) te[k] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        te[(i + j) % N] = (te[(i + j) % N] + ta[i] * tb_[j]) & MASK;
`ifdef SQ_REDUCE_EN
    last = te[N-1];
    for (int k = 0; k < N; k++) te[k] = (te[k] - last) & MASK;
`else
    last = 0;
`endif
  endtask

  task automatic do_load();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_a     = W'(ta[i]);
      in_b     = W'(tb_[i]);
      if (i == 0) chk("load_rdy", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_wait(input bit junk);
    int cyc = 0;
    in_valid = junk;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc), N * N);
  endtask

  task automatic do_drain(input bit bp, input bit rbp);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("valid", 32'(out_valid), 1);
      chk("data", 32'(out_data), 32'(te[k]));
      chk("last", 32'(out_last), 32'(k == N - 1));
      if (bp && k == 1) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("hold_v", 32'(out_valid), 1);
          chk("hold_d", 32'(out_data), 32'(te[k]));
          chk("hold_l", 32'(out_last), 0);
        end
        out_ready = 1'b1;
      end else if (rbp) begin
        while ($urandom_range(0, 2) == 0) begin
          out_ready = 1'b0;
          @(posedge clk); #1;
          chk("rhold_d", 32'(out_data), 32'(te[k]));
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("done_v", 32'(out_valid), 0);
    chk("done_rdy", 32'(in_ready), 1);
    chk("done_busy", 32'(busy), 0);
  endtask

  task automatic run_op(input bit bp, input bit rbp, input bit junk);
    model();
    do_load();
    chk("busy", 32'(busy), 1);
    do_wait(junk);
    do_drain(bp, rbp);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_v", 32'(out_valid), 0);
    chk("rst_l", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(out_data), 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    set4(1, 2, 3, 4, 1, 0, 0, 0);        run_op(0, 0, 0);
    set4(0, 0, 0, 5, 0, 3, 0, 0);        run_op(0, 0, 1);
    set4(8191, 0, 0, 0, 2, 0, 0, 0);     run_op(0, 0, 0);
    set4(4096, 0, 0, 0, 4096, 0, 0, 0);  run_op(0, 0, 0);
    set4(1, 1, 1, 1, 1, 2, 3, 4);        run_op(1, 0, 0);

    set_rand();
    model();
    do_load();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_v", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdy", 32'(in_ready), 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 32'(out_valid), 0);

    set4(1, 1, 1, 1, 1, 2, 3, 4);        run_op(0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      set_rand();
      run_op(0, 1, t[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
